// File: rtl/sync_bcd_down_timer.sv
// Programmable multi-digit BCD down-counter/timer with valid/ready preload,
// start/stop control, terminal-count done pulse and optional auto-reload.
module sync_bcd_down_timer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tick_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [4*DIGITS-1:0]   load_data_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  auto_reload_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  load_error_o
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   reload_q;
    logic [W-1:0]   reload_d;
    logic [W-1:0]   count_d;
    logic           done_d;
    logic           load_error_d;

    logic           load_accept;
    logic           load_ok;
    logic           count_zero;
    logic           count_one;

    // True when every nibble is a legal BCD digit.
    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // BCD decrement by one: a zero digit wraps to nine and borrows upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    assign load_accept = load_valid_i && (state_q != RUN);
    assign load_ok     = is_bcd(load_data_i);
    assign count_zero  = (count_o == '0);
    assign count_one   = (count_o == W'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (load_accept) begin
                    if (load_ok) begin
                        state_d = (start_i && (load_data_i != '0)) ? RUN : IDLE;
                    end
                end else if (start_i && !count_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tick_i && count_one && !auto_reload_i) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        count_d      = count_o;
        reload_d     = reload_q;
        done_d       = 1'b0;
        load_error_d = 1'b0;
        if (state_q == RUN) begin
            if (!stop_i && tick_i) begin
                if (count_one) begin
                    done_d  = 1'b1;
                    count_d = auto_reload_i ? reload_q : '0;
                end else begin
                    count_d = bcd_dec(count_o);
                end
            end
        end else if (load_accept) begin
            if (load_ok) begin
                count_d  = load_data_i;
                reload_d = load_data_i;
            end else begin
                load_error_d = 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o      <= '0;
            reload_q     <= '0;
            done_o       <= 1'b0;
            load_error_o <= 1'b0;
            running_o    <= 1'b0;
            load_ready_o <= 1'b1;
        end else begin
            count_o      <= count_d;
            reload_q     <= reload_d;
            done_o       <= done_d;
            load_error_o <= load_error_d;
            running_o    <= (state_d == RUN);
            load_ready_o <= (state_d != RUN);
        end
    end

endmodule

// File: tb/tb_sync_bcd_down_timer.sv
// Self-checking bench: directed scenarios then random stimulus, all compared
// against an integer-valued behavioural model of the timer.
module tb_sync_bcd_down_timer;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic           load_valid;
    logic           load_ready;
    logic [W-1:0]   load_data;
    logic           start;
    logic           stop;
    logic           auto_reload;
    logic [W-1:0]   count;
    logic           running;
    logic           done;
    logic           load_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: plain decimal values and a small mode number.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    int m_val;
    int m_rel;
    int m_st;
    bit m_done;
    bit m_err;

    sync_bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_data_i  (load_data),
        .start_i      (start),
        .stop_i       (stop),
        .auto_reload_i(auto_reload),
        .count_o      (count),
        .running_o    (running),
        .done_o       (done),
        .load_error_o (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bcd_legal(input logic [W-1:0] v);
        logic [W-1:0] t;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (t[3:0] > 4'd9) return 1'b0;
            t = t >> 4;
        end
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r;
        int scale;
        logic [W-1:0] t;
        r     = 0;
        scale = 1;
        t     = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r     = r + int'(t[3:0]) * scale;
            scale = scale * 10;
            t     = t >> 4;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Advance the reference model by one clock using the applied inputs.
    task automatic model_step();
        if (rst) begin
            m_val = 0; m_rel = 0; m_st = M_IDLE; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (m_st != M_RUN) begin
            if (load_valid) begin
                if (bcd_legal(load_data)) begin
                    m_val = bcd_to_int(load_data);
                    m_rel = m_val;
                    m_st  = (start && m_val != 0) ? M_RUN : M_IDLE;
                end else begin
                    m_err = 1;
                end
            end else if (start && m_val != 0) begin
                m_st = M_RUN;
            end
        end else if (stop) begin
            m_st = M_IDLE;
        end else if (tick) begin
            if (m_val == 1) begin
                m_done = 1;
                if (auto_reload) m_val = m_rel;
                else begin
                    m_val = 0;
                    m_st  = M_DONE;
                end
            end else begin
                m_val = m_val - 1;
            end
        end
    endtask

    task automatic compare_all();
        check("count",      32'(count),      32'(int_to_bcd(m_val)));
        check("running",    32'(running),    32'(m_st == M_RUN));
        check("load_ready", 32'(load_ready), 32'(m_st != M_RUN));
        check("done",       32'(done),       32'(m_done));
        check("load_error", 32'(load_error), 32'(m_err));
    endtask

    // Apply one cycle of inputs, clock it, update model, compare outputs.
    task automatic cyc(input bit r, input bit tk, input bit lv, input logic [W-1:0] ld,
                       input bit st, input bit sp, input bit ar);
        @(negedge clk);
        rst = r; tick = tk; load_valid = lv; load_data = ld;
        start = st; stop = sp; auto_reload = ar;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n, input bit ar);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, '0, 0, 0, ar);
    endtask

    logic [W-1:0] rnd_ld;
    bit           rnd_ar;

    initial begin
        rst = 1; tick = 0; load_valid = 0; load_data = '0;
        start = 0; stop = 0; auto_reload = 0;
        m_val = 0; m_rel = 0; m_st = M_IDLE; m_done = 0; m_err = 0;

        // Reset and simple countdown to terminal count
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0003, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0);
        ticks(3, 0);
        check("t1_count_zero", 32'(count), 32'h0);
        check("t1_done_pulse", 32'(done), 32'h1);
        cyc(0, 1, 0, '0, 0, 0, 0);
        check("t1_done_once", 32'(done), 32'h0);

        // Borrow across digits
        cyc(0, 0, 1, 16'h0100, 1, 0, 0);
        ticks(1, 0);
        check("t2_borrow_0099", 32'(count), 32'h0099);
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 1, 16'h1000, 1, 0, 0);
        ticks(1, 0);
        check("t2_borrow_0999", 32'(count), 32'h0999);
        cyc(0, 0, 0, '0, 0, 1, 0);

        // Auto-reload period of two ticks
        cyc(0, 0, 1, 16'h0002, 1, 0, 1);
        ticks(7, 1);
        check("t3_running", 32'(running), 32'h1);
        cyc(0, 0, 0, '0, 0, 1, 1);

        // Illegal load and load during RUN
        cyc(0, 0, 1, 16'h00A5, 0, 0, 0);
        check("t4_err_pulse", 32'(load_error), 32'h1);
        cyc(0, 0, 0, '0, 0, 0, 0);
        cyc(0, 0, 1, 16'h0050, 1, 0, 0);
        cyc(0, 0, 1, 16'h00A5, 0, 0, 0);
        check("t4_no_err_in_run", 32'(load_error), 32'h0);
        cyc(0, 0, 1, 16'h0007, 0, 0, 0);
        check("t4_run_load_ignored", 32'(count), 32'h0050);
        cyc(0, 0, 0, '0, 0, 1, 0);

        // Stop together with tick, resume, start at zero
        cyc(0, 0, 1, 16'h0010, 1, 0, 0);
        ticks(5, 0);
        cyc(0, 1, 0, '0, 0, 1, 0);
        check("t5_hold_0005", 32'(count), 32'h0005);
        cyc(0, 0, 0, '0, 1, 0, 0);
        ticks(1, 0);
        check("t5_resume_0004", 32'(count), 32'h0004);
        cyc(0, 0, 0, '0, 0, 1, 0);
        cyc(0, 0, 1, 16'h0000, 0, 0, 0);
        cyc(0, 0, 0, '0, 1, 0, 0);
        check("t5_zero_no_run", 32'(running), 32'h0);

        // Reset in the middle of RUN
        cyc(0, 0, 1, 16'h0050, 1, 0, 0);
        ticks(8, 0);
        check("t6_count_0042", 32'(count), 32'h0042);
        cyc(1, 1, 0, '0, 0, 0, 0);
        check("t6_rst_count", 32'(count), 32'h0);
        cyc(0, 1, 0, '0, 1, 0, 0);
        check("t6_start_ignored", 32'(running), 32'h0);

        // Random traffic
        rnd_ar = 0;
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 2))
                0:       rnd_ld = int_to_bcd(int'($urandom_range(1, 20)));
                1:       rnd_ld = int_to_bcd(int'($urandom_range(0, 9999)));
                default: rnd_ld = W'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) rnd_ar = ~rnd_ar;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0,
                rnd_ld,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 29) == 0,
                rnd_ar);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
